// File: rtl/pwm_seq_pkg.sv
// Shared constants for the PWM compare-value sequencer: address map,
// control/status bit positions and sequencer state encoding.
package pwm_seq_pkg;

   localparam int unsigned A_PT_LAST  = 'h07;
   localparam int unsigned A_SCTR     = 'h08;
   localparam int unsigned A_SLEN     = 'h09;
   localparam int unsigned A_SSTAT    = 'h0A;
   localparam int unsigned A_TBL_BASE = 'h10;
   localparam int unsigned A_TCMP0    = 'h03;
   localparam int unsigned A_TCMP1    = 'h06;

   localparam int unsigned SCTR_RUN   = 0;
   localparam int unsigned SCTR_LOOP  = 1;
   localparam int unsigned SCTR_CHAN  = 2;
   localparam int unsigned SSTAT_DONE = 4;
   localparam int unsigned SSTAT_OVR  = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_LOAD,
      S_WRITE,
      S_ADV
   } state_t;

endpackage

// File: rtl/pwm_seq_tbl.sv
// Compare-value table: one synchronous write port, one synchronous read port.
module pwm_seq_tbl
   import pwm_seq_pkg::*;
#(
   parameter int unsigned DW    = 16,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned IW    = 4
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [IW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [IW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   // Read-before-write: a same-cycle write to the read entry returns old data.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/pwm_seq.sv
// Timer register-port arbiter with a table playback engine that streams
// compare values into TCMP0/TCMP1 on each PWM period tick.
module pwm_seq
   import pwm_seq_pkg::*;
#(
   parameter int unsigned DW    = 16,
   parameter int unsigned AW    = 13,
   parameter int unsigned DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_en,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_din,
   input  logic          c_we,
   output logic [DW-1:0] c_dout,
   input  logic          tick,
   output logic [AW-1:0] t_addr,
   output logic [DW-1:0] t_din,
   output logic          t_we,
   input  logic [DW-1:0] t_dout
);

   localparam int unsigned IW = $clog2(DEPTH);

   state_t        r_state;
   logic          r_run, r_loop, r_chan, r_done, r_ovr;
   logic [IW-1:0] r_slen, r_idx;
   logic [DW-1:0] r_hold;
   logic          r_hold_vld;
   logic          r_src_pt, r_src_tbl, r_retry;
   logic [IW-1:0] r_retry_idx;
   logic [DW-1:0] r_local;

   logic          w_cpu_bus, w_sctr_wr, w_slen_wr, w_tbl_hit, w_tbl_wr, w_tbl_rd;
   logic          w_port_busy, w_retry_go, w_cpu_rd_go;
   logic [IW-1:0] w_tbl_idx, w_raddr;
   logic [DW-1:0] w_rdata, w_hold, w_local;
   logic [AW-1:0] w_tgt;

   assign w_cpu_bus = c_en && (c_addr <= AW'(A_PT_LAST));
   assign w_sctr_wr = c_en && c_we && (c_addr == AW'(A_SCTR));
   assign w_slen_wr = c_en && c_we && (c_addr == AW'(A_SLEN));
   assign w_tbl_hit = c_en && (c_addr >= AW'(A_TBL_BASE)) && (c_addr < AW'(A_TBL_BASE + DEPTH));
   assign w_tbl_wr  = w_tbl_hit && c_we;
   assign w_tbl_rd  = w_tbl_hit && !c_we;
   assign w_tbl_idx = c_addr[IW-1:0];

   // LOAD owns the read port; a displaced CPU read is replayed the next cycle.
   assign w_port_busy = (r_state == S_LOAD) || r_retry;
   assign w_retry_go  = r_retry && (r_state != S_LOAD);
   assign w_cpu_rd_go = w_tbl_rd && !w_port_busy;
   assign w_raddr     = (r_state == S_LOAD) ? r_idx : (r_retry ? r_retry_idx : w_tbl_idx);

   assign w_hold = r_hold_vld ? r_hold : w_rdata;
   assign w_tgt  = r_chan ? AW'(A_TCMP1) : AW'(A_TCMP0);

   pwm_seq_tbl #(.DW(DW), .DEPTH(DEPTH), .IW(IW)) u_tbl (
      .clk     (clk),
      .i_we    (w_tbl_wr),
      .i_waddr (w_tbl_idx),
      .i_wdata (c_din),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   always_comb begin
      t_we   = 1'b0;
      t_addr = '0;
      t_din  = '0;
      if (w_cpu_bus) begin
         t_we   = c_we;
         t_addr = c_addr;
         t_din  = c_din;
      end else if (r_state == S_WRITE) begin
         t_we   = 1'b1;
         t_addr = w_tgt;
         t_din  = w_hold;
      end
   end

   always_comb begin
      w_local = '0;
      if (c_en && !c_we) begin
         if (c_addr == AW'(A_SCTR)) begin
            w_local[SCTR_RUN]  = r_run;
            w_local[SCTR_LOOP] = r_loop;
            w_local[SCTR_CHAN] = r_chan;
         end else if (c_addr == AW'(A_SLEN)) begin
            w_local[IW-1:0] = r_slen;
         end else if (c_addr == AW'(A_SSTAT)) begin
            w_local[IW-1:0]   = r_idx;
            w_local[SSTAT_DONE] = r_done;
            w_local[SSTAT_OVR]  = r_ovr;
         end
      end
   end

   assign c_dout = r_src_pt ? t_dout : (r_src_tbl ? w_rdata : r_local);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_src_pt    <= 1'b0;
         r_src_tbl   <= 1'b0;
         r_local     <= '0;
         r_retry     <= 1'b0;
         r_retry_idx <= '0;
      end else begin
         r_src_pt  <= w_cpu_bus && !c_we;
         r_src_tbl <= w_retry_go || w_cpu_rd_go;
         r_local   <= w_local;
         r_retry   <= (w_tbl_rd && w_port_busy) || (r_retry && !w_retry_go);
         if (w_tbl_rd && w_port_busy) r_retry_idx <= w_tbl_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_run      <= 1'b0;
         r_loop     <= 1'b0;
         r_chan     <= 1'b0;
         r_done     <= 1'b0;
         r_ovr      <= 1'b0;
         r_slen     <= '0;
         r_idx      <= '0;
         r_hold     <= '0;
         r_hold_vld <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: ;
            S_WAIT: if (tick) r_state <= S_LOAD;
            S_LOAD: begin
               r_hold_vld <= 1'b0;
               r_state    <= S_WRITE;
            end
            S_WRITE: begin
               if (!r_hold_vld) begin
                  r_hold     <= w_rdata;
                  r_hold_vld <= 1'b1;
               end
               if (!w_cpu_bus) r_state <= S_ADV;
            end
            S_ADV: begin
               if (r_idx == r_slen) begin
                  if (r_loop) begin
                     r_idx   <= '0;
                     r_state <= S_WAIT;
                  end else begin
                     r_done  <= 1'b1;
                     r_run   <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= S_WAIT;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (tick && r_run && (r_state inside {S_LOAD, S_WRITE, S_ADV})) r_ovr <= 1'b1;
         if (w_slen_wr) r_slen <= c_din[IW-1:0];

         if (w_sctr_wr) begin
            r_run  <= c_din[SCTR_RUN];
            r_loop <= c_din[SCTR_LOOP];
            r_chan <= c_din[SCTR_CHAN];
            r_ovr  <= 1'b0;
            if (!c_din[SCTR_RUN]) begin
               r_state <= S_IDLE;
               r_idx   <= '0;
            end else if (r_state == S_IDLE) begin
               r_state <= S_WAIT;
               r_idx   <= '0;
               r_done  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pwm_seq.sv
// Self-checking bench for pwm_seq: directed scenarios plus randomized playback
// compared against a table/tick-count reference model and a timer register model.
module tb_pwm_seq;

   logic        clk = 1'b0;
   logic        rst, c_en, c_we, tick, t_we;
   logic [12:0] c_addr, t_addr;
   logic [15:0] c_din, c_dout, t_din;
   logic [15:0] t_dout = '0;

   typedef struct {
      int          cyc;
      logic [12:0] a;
      logic [15:0] d;
   } wr_t;

   wr_t         q[$];
   logic [15:0] tbl [16];
   logic [15:0] tregs [8];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   pwm_seq #(.DW(16), .AW(13), .DEPTH(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .c_en   (c_en),
      .c_addr (c_addr),
      .c_din  (c_din),
      .c_we   (c_we),
      .c_dout (c_dout),
      .tick   (tick),
      .t_addr (t_addr),
      .t_din  (t_din),
      .t_we   (t_we),
      .t_dout (t_dout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Timer peripheral: registered read, write on t_we.
   always @(posedge clk) begin
      if (t_we && t_addr < 13'd8) tregs[t_addr[2:0]] <= t_din;
      t_dout <= tregs[t_addr[2:0]];
   end

   // Record every sequencer-originated timer write.
   always @(negedge clk) begin
      if (!rst && t_we && !(c_en && c_addr <= 13'h7))
         q.push_back('{cyc, t_addr, t_din});
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [12:0] a, input logic [15:0] d);
      c_en = 1'b1; c_we = 1'b1; c_addr = a; c_din = d;
      step();
      c_en = 1'b0; c_we = 1'b0;
   endtask

   task automatic cpu_read(input logic [12:0] a, input logic [15:0] exp, input string tag);
      c_en = 1'b1; c_we = 1'b0; c_addr = a;
      step();
      c_en = 1'b0;
      @(negedge clk);
      chk(tag, c_dout, exp);
   endtask

   task automatic pulse_tick(output int at);
      tick = 1'b1;
      at = cyc;
      step();
      tick = 1'b0;
   endtask

   // Play a sequence: expected writes are tbl[k mod L], each two cycles after its tick.
   task automatic play(input int L, input int lp, input int ch, input int nt, input string tag);
      int tcyc[$];
      int t;
      for (int i = 0; i < 16; i++) cpu_write(13'(16 + i), tbl[i]);
      cpu_write(13'h9, 16'(L - 1));
      cpu_write(13'h8, 16'(ch * 4 + lp * 2 + 1));
      q.delete();
      for (int k = 0; k < nt; k++) begin
         pulse_tick(t);
         tcyc.push_back(t);
         repeat ($urandom_range(3, 6)) step();
      end
      repeat (4) step();
      chk({tag, " nwr"}, q.size(), nt);
      for (int k = 0; k < nt && k < q.size(); k++) begin
         chk({tag, " cyc"}, q[k].cyc, tcyc[k] + 2);
         chk({tag, " addr"}, q[k].a, (ch != 0) ? 13'h6 : 13'h3);
         chk({tag, " data"}, q[k].d, tbl[k % L]);
      end
      if (lp == 0) begin
         cpu_read(13'hA, 16'h10 | 16'(L - 1), {tag, " sstat"});
         cpu_read(13'h8, 16'(ch * 4 + lp * 2), {tag, " sctr"});
      end else begin
         cpu_read(13'hA, 16'(nt % L), {tag, " sstat"});
         cpu_write(13'h8, 16'h0);
         cpu_read(13'hA, 16'h0, {tag, " sstat stop"});
      end
   endtask

   initial begin
      int n;
      for (int i = 0; i < 8; i++) tregs[i] = 16'h1000 + 16'(i);
      rst = 1'b1; c_en = 1'b0; c_we = 1'b0; c_addr = '0; c_din = '0; tick = 1'b0;
      step(); step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst t_we", t_we, 0);
      chk("rst t_addr", t_addr, 0);
      chk("rst t_din", t_din, 0);
      chk("rst c_dout", c_dout, 0);
      cpu_read(13'hA, 16'h0, "rst sstat");
      cpu_read(13'h8, 16'h0, "rst sctr");
      cpu_read(13'h9, 16'h0, "rst slen");

      for (int i = 0; i < 16; i++) tbl[i] = 16'($urandom);
      tbl[0] = 16'h0100; tbl[1] = 16'h0200; tbl[2] = 16'h0300;
      play(3, 0, 0, 3, "seq1");
      cpu_read(13'h3, 16'h0300, "tcmp0");
      play(3, 1, 1, 5, "seq2");
      cpu_read(13'h6, 16'h0200, "tcmp1");

      // CPU holds the bus for three cycles while the sequencer write is pending.
      cpu_write(13'h10, 16'hBEEF);
      cpu_write(13'h9, 16'h0);
      cpu_write(13'h8, 16'h1);
      q.delete();
      pulse_tick(n);
      step();
      c_en = 1'b1; c_we = 1'b1; c_addr = 13'h3; c_din = 16'h1234;
      @(negedge clk);
      chk("stall cpu we", t_we, 1);
      chk("stall cpu addr", t_addr, 13'h3);
      chk("stall cpu din", t_din, 16'h1234);
      step(); step(); step();
      c_en = 1'b0; c_we = 1'b0;
      @(negedge clk);
      chk("stall seq we", t_we, 1);
      chk("stall seq din", t_din, 16'hBEEF);
      repeat (3) step();
      chk("stall nwr", q.size(), 1);
      if (q.size() > 0) chk("stall cyc", q[0].cyc, n + 5);
      cpu_read(13'h3, 16'hBEEF, "stall tcmp0");
      cpu_read(13'hA, 16'h10, "stall sstat");

      // Second tick arrives while the first write is still in flight.
      cpu_write(13'h9, 16'h3);
      cpu_write(13'h8, 16'h3);
      q.delete();
      pulse_tick(n);
      step();
      pulse_tick(n);
      repeat (6) step();
      chk("ovr nwr", q.size(), 1);
      cpu_read(13'hA, 16'h21, "ovr sstat");
      cpu_write(13'h8, 16'h3);
      cpu_read(13'hA, 16'h01, "ovr cleared");
      cpu_write(13'h8, 16'h0);

      // Clear run while the entry is being loaded.
      cpu_write(13'h8, 16'h3);
      pulse_tick(n);
      repeat (5) step();
      q.delete();
      pulse_tick(n);
      c_en = 1'b1; c_we = 1'b1; c_addr = 13'h8; c_din = 16'h0;
      step();
      c_en = 1'b0; c_we = 1'b0;
      repeat (4) step();
      chk("abort nwr", q.size(), 0);
      cpu_read(13'hA, 16'h0, "abort sstat");

      // Reset lands during the sequencer write.
      cpu_write(13'h9, 16'h0);
      cpu_write(13'h8, 16'h1);
      pulse_tick(n);
      step();
      @(negedge clk);
      chk("rstw pre we", t_we, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rstw t_we", t_we, 0);
      chk("rstw t_addr", t_addr, 0);
      chk("rstw t_din", t_din, 0);
      chk("rstw c_dout", c_dout, 0);
      cpu_read(13'h8, 16'h0, "rstw sctr");
      cpu_read(13'hA, 16'h0, "rstw sstat");

      for (int r = 0; r < 6; r++) begin
         int L, lp, ch, nt;
         for (int i = 0; i < 16; i++) tbl[i] = 16'($urandom);
         L  = $urandom_range(1, 16);
         lp = $urandom_range(0, 1);
         ch = $urandom_range(0, 1);
         nt = (lp != 0) ? $urandom_range(1, 2 * L + 2) : L;
         play(L, lp, ch, nt, $sformatf("rnd%0d", r));
         for (int i = 0; i < 3; i++) begin
            int e = $urandom_range(0, 15);
            cpu_read(13'(16 + e), tbl[e], $sformatf("rnd%0d tbl%0d", r, e));
         end
      end

      cpu_read(13'h0, 16'h1000, "pt read0");
      cpu_write(13'h9, 16'h5);
      cpu_read(13'h9, 16'h5, "slen read");
      cpu_read(13'hB, 16'h0, "unmapped read");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pwm_seq.md
# pwm_seq

Compare-value sequencer for the timer/PWM register port. It owns the single register bus into the timer peripheral and arbitrates it between the CPU and an internal playback engine. The engine streams a 16-entry table of compare values into TCMP0 or TCMP1, one entry per PWM period tick, so waveforms play back without CPU intervention. It sits between the CPU data bus and the timer peripheral.

## Interface
- DW, 16, data width
- AW, 13, address width
- DEPTH, 16, table entries (index width 4)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- c_en  in  1  CPU access valid this cycle
- c_addr  in  AW  CPU address
- c_din  in  DW  CPU write data
- c_we  in  1  CPU write enable (qualified by c_en)
- c_dout  out  DW  CPU read data, registered
- tick  in  1  single-cycle period-boundary pulse (timer underflow)
- t_addr  out  AW  timer register address
- t_din  out  DW  timer write data
- t_we  out  1  timer write enable
- t_dout  in  DW  timer read data (valid one cycle after address)

## Operation
- Address map (c_addr): 0x00–0x07 pass through to timer; 0x08 SCTR; 0x09 SLEN; 0x0A SSTAT (read-only); 0x10–0x1F table[0..15] (write/read). Other addresses: writes ignored, reads return 0.
- SCTR: [0] run, [1] loop, [2] chan (0 → target 0x03 TCMP0, 1 → 0x06 TCMP1). Any SCTR write clears ovr.
- SLEN[3:0]: last table index played (length = SLEN+1).
- SSTAT: [3:0] idx, [4] done, [5] ovr (tick arrived outside WAIT while running).
- Arbitration: CPU wins whenever c_en=1 and c_addr≤0x07; t_addr/t_din/t_we follow CPU combinationally that cycle. Otherwise the sequencer drives the bus. Idle bus: t_we=0, t_addr=0, t_din=0.
- FSM: IDLE → (run written 1) WAIT, idx=0, done=0. WAIT → (tick) LOAD. LOAD: table[idx] read into holding reg → WRITE. WRITE: t_we=1, t_addr=target, t_din=hold; stays in WRITE while CPU owns bus. After the write completes → ADV. ADV: if idx==SLEN then (loop: idx=0, WAIT) else (done=1, run=0, IDLE); otherwise idx+1, WAIT.
- run written 0 in any state: next state IDLE, pending write aborted, idx=0, done unchanged.
- tick in LOAD/WRITE/ADV while running: ovr=1, tick dropped. tick in IDLE ignored.
- CPU table write during playback is allowed; a write to the entry being loaded in the same cycle returns the old value.
- c_dout: if the previous cycle was a CPU read of 0x00–0x07, c_dout=t_dout; otherwise it is the registered local read of the previous-cycle address.

## Timing
- Reset: state IDLE, SCTR=SLEN=0, idx=0, done=ovr=0, c_dout=0, t_we=0, t_addr=0, t_din=0. Table contents are undefined after reset.
- tick at cycle N (WAIT): LOAD at N+1, timer write at N+2 when the bus is free; each stalled cycle adds 1.
- Minimum tick spacing without ovr: 4 cycles.
- Local register read latency: 1 cycle. Pass-through read: 1 cycle (timer registered).
- Reset asserted mid-write: t_we=0 in the cycle after the reset edge.

## Structure
- Shared package: address constants (window bounds, SCTR/SLEN/SSTAT/table base, TCMP0/TCMP1 addresses), SCTR/SSTAT bit positions, FSM state encoding.
- One sub-module: pwm_seq_tbl, a DEPTH×DW table with synchronous read, one write port (CPU) and one read port shared by CPU read and LOAD. LOAD has priority; a colliding CPU table read returns data from the next cycle. The remaining logic (FSM, arbiter, read mux) stays in the top.

## Test plan
- Write table[0..2]=0x0100,0x0200,0x0300, SLEN=2, SCTR=0x1; give 3 ticks → t_we pulses with t_addr=0x03 and data 0x0100/0x0200/0x0300, then SSTAT=0x12 (done, idx=2) and run=0.
- Same setup with SCTR=0x7 (loop, chan1), 5 ticks → writes to 0x06 of 0x100,0x200,0x300,0x100,0x200.
- CPU write to 0x03 held for 3 cycles at N+2 → CPU data reaches the timer, and the sequencer write appears at N+5 with table data.
- Two ticks 2 cycles apart → one write only, SSTAT[5]=1; a write to SCTR clears it.
- run cleared during LOAD → no t_we, state IDLE, idx=0; rst asserted during WRITE → all outputs at reset values on the next cycle.
- CPU read of 0x00, then 0x09 → c_dout is the timer value, then SLEN one cycle later; a read of 0x0B returns 0.
